mult_seq: RTL and testbench

- Iterative shift-add multiplier for MIPS MULT/MULTU, sitting directly around the 32-bit carry-lookahead adder.
- Each cycle it feeds the adder's A/B operands and consumes its Sum/Cout, one multiplier bit per cycle.
- Writes the 64-bit product into HI/LO registers read by MFHI/MFLO.
- The control unit starts it with a one-cycle pulse and stalls on busy.

---
 rtl/mult_seq_if.sv | 24 ++
 rtl/mult_seq.sv | 201 ++++++++++++++++++++
 tb/tb_mult_seq.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mult_seq_if.sv
// mult_seq_if: request/result bundle between the control unit and the
// iterative multiplier.
//   start     - one-cycle request pulse (control -> multiplier)
//   signed_op - 1 = MULT, 0 = MULTU, sampled with start
//   a, b      - multiplicand / multiplier, sampled with start
//   busy      - operation in flight, control unit stalls on it
//   done      - one-cycle completion pulse, hi/lo valid
//   hi, lo    - upper / lower halves of the 64-bit product
// Modports: master = control unit side, slave = multiplier side.
interface mult_seq_if;
  logic        start;
  logic        signed_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, output signed_op, output a, output b,
                  input  busy,  input  done,      input  hi, input  lo);
  modport slave  (input  start, input  signed_op, input  a, input  b,
                  output busy,  output done,      output hi, output lo);
endinterface

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier for MIPS MULT/MULTU wrapped around
// a 32-bit carry-lookahead adder. One multiplier bit is consumed per cycle;
// the 64-bit product lands in the HI/LO registers read by MFHI/MFLO.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous, active-high reset (aborts any operation, clears hi/lo)
//   bus - mult_seq_if.slave (start/signed_op/a/b in, busy/done/hi/lo out)
// Parameter WIDTH: operand width, only 32 is supported.
// Optional feature macro MULT_EARLY_TERM_EN: once all unprocessed multiplier
// bits are zero, an ALIGN state shifts the partial product into place in one
// cycle instead of iterating through the zero bits.
module mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mult_seq_if.slave   bus
);

  if (WIDTH != 32) begin : g_bad_width
    $error("mult_seq: only WIDTH=32 is supported");
  end

`ifdef MULT_EARLY_TERM_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIX   = 2'd2,
    S_ALIGN = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIX   = 2'd2
  } state_e;
`endif

  // 32-bit adder: 4-bit groups with group generate/propagate lookahead,
  // returns {cout, sum}.
  function automatic logic [32:0] cla_add(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        cin);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [8:0]  gc;
    logic        gg;
    logic        gp;
    g     = x & y;
    p     = x ^ y;
    c     = 33'd0;
    gc    = 9'd0;
    gc[0] = cin;
    for (int j = 0; j < 8; j++) begin
      gg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp = &p[4*j +: 4];
      gc[j+1] = gg | (gp & gc[j]);
      c[4*j]  = gc[j];
      for (int i = 1; i < 4; i++) begin
        c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
      end
    end
    c[32] = gc[8];
    return {c[32], p ^ c[31:0]};
  endfunction

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;       // multiplicand magnitude
  logic [31:0] u_q, u_d;       // upper half of partial product
  logic [31:0] q_q, q_d;       // multiplier bits / lower product bits
  logic        neg_q, neg_d;   // result must be negated in FIX
  logic [5:0]  cnt_q, cnt_d;   // iterations already performed
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] add_s;          // {cout, sum} from the adder
  logic [63:0] uq_s;
  logic [63:0] fixed_s;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    u_d     = u_q;
    q_d     = q_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // Adder adds M only when the current multiplier bit is set; otherwise
    // it passes U through with a zero carry.
    add_s   = cla_add(u_q, q_q[0] ? m_q : 32'd0, 1'b0);
    uq_s    = {u_q, q_q};
    fixed_s = neg_q ? (~uq_s + 64'd1) : uq_s;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // Magnitudes; |0x80000000| stays 0x80000000 read as unsigned.
          if (bus.signed_op) begin
            m_d   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
            q_d   = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
            neg_d = bus.a[31] ^ bus.b[31];
          end else begin
            m_d   = bus.a;
            q_d   = bus.b;
            neg_d = 1'b0;
          end
          u_d     = 32'd0;
          cnt_d   = 6'd0;
          state_d = S_CALC;
`ifdef MULT_EARLY_TERM_EN
          if (q_d == 32'd0) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_CALC;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        // {cout, sum, Q} shifted right by one.
        u_d   = add_s[32:1];
        q_d   = {add_s[0], q_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
`ifdef MULT_EARLY_TERM_EN
          // Remaining multiplier bits now sit in q_d[30-cnt_q:0].
          if ((q_d & (32'hFFFF_FFFF >> (cnt_q + 6'd1))) == 32'd0) begin
            state_d = S_ALIGN;
          end else begin
            state_d = S_CALC;
          end
`endif
        end
      end
`ifdef MULT_EARLY_TERM_EN
      S_ALIGN: begin
        // Each skipped zero-bit iteration is a plain right shift of {U,Q}.
        {u_d, q_d} = uq_s >> (6'd32 - cnt_q);
        state_d    = S_FIX;
      end
`endif
      S_FIX: begin
        hi_d    = fixed_s[63:32];
        lo_d    = fixed_s[31:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= 32'd0;
      u_q     <= 32'd0;
      q_q     <= 32'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      u_q     <= u_d;
      q_q     <= q_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq. Expected products come from
// 64-bit arithmetic and expected latency from the multiplier's magnitude.
module tb_mult_seq;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mult_seq_if bus ();

  mult_seq #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic sgn);
    logic [63:0] r;
    if (sgn) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    else     r = {32'd0, a} * {32'd0, b};
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] b, input logic sgn);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int h;
    mag = (sgn && b[31]) ? (32'd0 - b) : b;
    h = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) h = i + 1;
    return (h < 32) ? h + 3 : 34;
`else
    return 34;
`endif
  endfunction

  // Issue one operation at a negedge with DUT ready; returns at the negedge of
  // the done cycle (lat = 0 if done never came within the budget).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, output int lat,
                       output logic [31:0] hi, output logic [31:0] lo,
                       output bit busy_ok, output bit hold_ok);
    logic [31:0] hi0, lo0;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.signed_op = sgn;
    hi0 = bus.hi; lo0 = bus.lo;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.hi !== hi0 || bus.lo !== lo0) hold_ok = 1'b0;
      @(negedge clk);
    end
    hi = bus.hi; lo = bus.lo;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = 32'd0; bus.b = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.done); end
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h exp 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h exp 0", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] ta [10] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0000, 32'd9,
                            32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] tb [10] = '{32'd5, 32'hFFFF_FFFF, 32'd3, 32'h8000_0000, 32'd5,
                            32'd0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic        ts [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int lat; logic [31:0] hi, lo; bit bok, hok; logic [63:0] e;
    for (int i = 0; i < 10; i++) begin
      do_op(ta[i], tb[i], ts[i], lat, hi, lo, bok, hok);
      e = ref_prod(ta[i], tb[i], ts[i]);
      n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL dir%0d_prod got %h exp %h", i, {hi, lo}, e); end
      n_tests++; if (lat !== ref_lat(tb[i], ts[i])) begin n_fail++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, ref_lat(tb[i], ts[i])); end
      n_tests++; if (!bok) begin n_fail++; $display("FAIL dir%0d_busy got bad exp busy until done", i); end
      n_tests++; if (!hok) begin n_fail++; $display("FAIL dir%0d_hold got change exp stable hi/lo", i); end
      @(negedge clk);
    end
    // Spec-literal spot checks.
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, hi, lo, bok, hok);
    n_tests++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_ff got %h_%h exp fffffffe_00000001", hi, lo); end
    @(negedge clk);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, hi, lo, bok, hok);
    n_tests++; if (hi !== 32'h4000_0000 || lo !== 32'd0) begin n_fail++; $display("FAIL mult_min got %h_%h exp 40000000_00000000", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int lat; logic [31:0] hi, lo; bit bok, hok; int done_at;
    bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd5; bus.signed_op = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin done_at = k; break; end
      if (k == 10) begin bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd7; end
      if (k == 11) bus.start = 1'b0;
      @(negedge clk);
    end
    n_tests++; if (done_at !== ref_lat(32'd5, 1'b0)) begin n_fail++; $display("FAIL ignore_latency got %0d exp %0d", done_at, ref_lat(32'd5, 1'b0)); end
    n_tests++; if (bus.lo !== 32'd15 || bus.hi !== 32'd0) begin n_fail++; $display("FAIL ignore_result got %h_%h exp 0_f", bus.hi, bus.lo); end
    // Start accepted in the done cycle.
    do_op(32'd7, 32'd7, 1'b0, lat, hi, lo, bok, hok);
    n_tests++; if (lat !== ref_lat(32'd7, 1'b0)) begin n_fail++; $display("FAIL done_cycle_start_latency got %0d exp %0d", lat, ref_lat(32'd7, 1'b0)); end
    n_tests++; if (lo !== 32'd49) begin n_fail++; $display("FAIL done_cycle_start_lo got %0d exp 49", lo); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] hi, lo; bit bok, hok; bit saw_done;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, hi, lo, bok, hok);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2; bus.signed_op = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;                       // cycle N+20
    @(negedge clk);
    rst = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    n_tests++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin n_fail++; $display("FAIL abort_hilo got %h_%h exp 0_0", bus.hi, bus.lo); end
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done !== 1'b0) saw_done = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL abort_no_done got pulse exp none"); end
    do_op(32'd3, 32'd5, 1'b0, lat, hi, lo, bok, hok);
    n_tests++; if (lo !== 32'd15 || lat !== ref_lat(32'd5, 1'b0)) begin n_fail++; $display("FAIL abort_recover got lo=%0d lat=%0d exp lo=15 lat=%0d", lo, lat, ref_lat(32'd5, 1'b0)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back_random();
    int lat; logic [31:0] hi, lo, a, b; logic s; bit bok, hok; logic [63:0] e;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) b = -b;
      s = 1'(($urandom & 32'd1));
      do_op(a, b, s, lat, hi, lo, bok, hok);   // next op starts in done cycle
      e = ref_prod(a, b, s);
      n_tests++; if ({hi, lo} !== e) begin n_fail++; $display("FAIL rnd%0d_prod a=%h b=%h s=%b got %h exp %h", i, a, b, s, {hi, lo}, e); end
      n_tests++; if (lat !== ref_lat(b, s)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, lat, ref_lat(b, s)); end
      n_tests++; if (!bok || !hok) begin n_fail++; $display("FAIL rnd%0d_busy_hold got busy_ok=%b hold_ok=%b exp 1 1", i, bok, hok); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
